alu_sequencer: RTL and testbench
================================

# alu_sequencer

Controls the bit-serial ALU. Accepts one decoded ALU operation at a time from the instruction decoder through a valid/ready handshake. Holds the operation's control word stable while the operation runs. Drives `advance`/`regfile_en` one NSHIFT-bit step at a time, and stalls a step whenever serial memory data is missing or the memory sink is not ready. Reports each completed operation to the decoder with a tag, so the ALU only ever sees a legal op sequence.

## Interface
Parameters:
- `LOG2_NR`, 4, register index width
- `REG_BITS`, 8, register width
- `NSHIFT`, 2, bits per ALU step
- `OP_BITS`, `` `OP_BITS ``, ALU operation code width
- `TAG_BITS`, 3, requester tag width

Ports:
- `clk`  in  1  clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_op`  in  `alu_op_t`  operation descriptor (operation, reg1, reg2, pair_op, pair_op2, sext2, external_arg1/2, update_reg1, reverse_args, update_carry_flags, update_other_flags, needs_in, needs_out)
- `req_tag`  in  `TAG_BITS`  opaque tag, returned on completion
- `in_valid`  in  1  external serial source has the next NSHIFT bits on `data_in1/2`
- `out_ready`  in  1  external sink accepts `data_out` this cycle
- `alu_ctrl`  out  `alu_op_t`  registered control word, fanned out to the ALU ports
- `alu_advance`  out  1  ALU advance
- `alu_regfile_en`  out  1  equal to `alu_advance`
- `alu_op_done`  in  1  ALU last-step indication
- `done_valid`  out  1  one-cycle completion pulse
- `done_tag`  out  `TAG_BITS`  tag of the completed op
- `busy`  out  1  an operation is running or buffered

## Operation
- FSM states are IDLE and RUN.
- **Accept in IDLE:** a handshake in IDLE loads `cur_op`/`cur_tag` and moves to RUN.
- **Step enable in RUN:** `step = (!cur_op.needs_in || in_valid) && (!cur_op.needs_out || out_ready)`. `alu_advance = alu_regfile_en = step`.
- **Stalls:** a step may be stalled for any number of cycles. The ALU state and control word are held unchanged throughout.
- **Last step:** the step that completes the op is the cycle where `step && alu_op_done`. On it, `done_valid` pulses and `done_tag <= cur_tag` on the next cycle. The FSM then goes to IDLE, or reloads from the skid buffer when that option is compiled in and the buffer holds an op.
- **Step counts:** exactly `REG_BITS/NSHIFT` steps (4) when `!pair_op`; `2*REG_BITS/NSHIFT` (8) when `pair_op`. Count is fixed by the ALU, not by the sequencer.
- **`alu_ctrl`:** changes only on an accept edge or a last-step edge, never mid-operation.
- **`req_ready`:** without the skid option, `req_ready = (state == IDLE)`.
- **Reset:**
  - FSM to IDLE, skid buffer emptied.
  - `alu_advance`, `alu_regfile_en`, `done_valid` and `busy` are 0; `alu_ctrl` and `done_tag` are 0; `req_ready` is 1.
  - A reset mid-operation abandons the op: no `done_valid` is produced for it.
- **Simultaneous events:** a last step and a new handshake in the same cycle are legal. The new op starts next cycle (skid build), or the request is held off by `req_ready = 0` (non-skid build).

## Timing
- Request accepted in cycle t; RUN begins in t+1. The first step can occur in t+1.
- Unstalled single-byte op: steps in t+1..t+4; `done_valid` in t+5.
- Unstalled pair op: steps in t+1..t+8; `done_valid` in t+9.
- Each stalled cycle delays completion by exactly one cycle.
- `done_valid` is registered; every other output is driven from flops or from the `step` expression only.
- No combinational path from `req_valid` to `alu_advance`.

## Configuration
- **Macro `ALU_SEQ_SKID_EN`:**
  - One-entry skid buffer; `req_ready = !skid_full`, so a request can be accepted while RUN.
  - On a last step with the skid full, the buffered op is loaded directly. The new op's first step can occur the very next cycle (zero bubble), which satisfies the ALU rule that a new op must follow `op_done` immediately.
- **Macro undefined:** no buffer; exactly one idle cycle between back-to-back ops.

## Structure
- **Shared package `alu_pkg`:** the `alu_op_t` packed struct, and state encodings `SEQ_IDLE`/`SEQ_RUN`. The same `alu_op_t` is used by the decoder.
- **Sub-module `alu_seq_skid`:** holds the skid buffer. It is instantiated only under `ALU_SEQ_SKID_EN`.
- FSM and step logic live in the top module.

## Test plan
- **Single ADD:** ADD, `pair_op = 0`, no external data, accepted cycle 0 → `alu_advance` high cycles 1–4, `done_valid` cycle 5 with `done_tag` = request tag (5).
- **Pair MOV:** `pair_op = 1` → 8 consecutive steps, `done_valid` at cycle 9, `alu_ctrl` constant cycles 1–8.
- **Input stall:** `needs_in = 1`, `in_valid` low in cycles 2–3 → `alu_advance` low exactly those cycles, ALU counter frozen, `done_valid` at cycle 7.
- **Back-to-back:** two requests back-to-back.
  - With `ALU_SEQ_SKID_EN`: second op's first step in the cycle after the first op's last step.
  - Without it: one bubble, second `done_valid` 1 cycle later.
- **Reset mid-op:** assert `reset` at step 2 of a pair op → next cycle `alu_advance = 0`, `busy = 0`, `req_ready = 1`; no `done_valid` for the abandoned tag.
- **Output backpressure:** `needs_out = 1`, `out_ready` toggling 1,0,1,0 → step only on `out_ready = 1` cycles; completion after 8 cycles for a single-byte op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared decode types for the bit-serial ALU and its sequencer state encoding.
// OP_BITS may be predefined on the command line; it defaults to 6.
`ifndef OP_BITS
`define OP_BITS 6
`endif

package alu_pkg;

  localparam int unsigned AluOpBits = `OP_BITS;
  localparam int unsigned AluLog2Nr = 4;

  typedef struct packed {
    logic [AluOpBits-1:0] operation;
    logic [AluLog2Nr-1:0] reg1;
    logic [AluLog2Nr-1:0] reg2;
    logic                 pair_op;
    logic                 pair_op2;
    logic                 sext2;
    logic                 external_arg1;
    logic                 external_arg2;
    logic                 update_reg1;
    logic                 reverse_args;
    logic                 update_carry_flags;
    logic                 update_other_flags;
    logic                 needs_in;
    logic                 needs_out;
  } alu_op_t;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/alu_seq_skid.sv
// One-entry skid buffer holding a decoded op and its tag while the current op runs.
module alu_seq_skid
  import alu_pkg::*;
#(
  parameter int unsigned TagBits = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  alu_op_t            op_i,
  input  logic [TagBits-1:0] tag_i,
  output logic               full_o,
  output alu_op_t            op_o,
  output logic [TagBits-1:0] tag_o
);

  logic               full_q, full_d;
  alu_op_t            op_q, op_d;
  logic [TagBits-1:0] tag_q, tag_d;

  always_comb begin
    full_d = full_q;
    op_d   = op_q;
    tag_d  = tag_q;
    // Push is only offered while empty, so pop and push never collide.
    if (pop_i) begin
      full_d = 1'b0;
    end
    if (push_i) begin
      full_d = 1'b1;
      op_d   = op_i;
      tag_d  = tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      op_q   <= '0;
      tag_q  <= '0;
    end else begin
      full_q <= full_d;
      op_q   <= op_d;
      tag_q  <= tag_d;
    end
  end

  assign full_o = full_q;
  assign op_o   = op_q;
  assign tag_o  = tag_q;

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one decoded op at a time through the bit-serial ALU, stalling on serial I/O.
// Define ALU_SEQ_SKID_EN to add a one-entry skid buffer for zero-bubble back-to-back ops.
`ifndef OP_BITS
`define OP_BITS 6
`endif

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned LOG2_NR  = 4,
  parameter int unsigned REG_BITS = 8,
  parameter int unsigned NSHIFT   = 2,
  parameter int unsigned OP_BITS  = `OP_BITS,
  parameter int unsigned TAG_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  alu_op_t             req_op,
  input  logic [TAG_BITS-1:0] req_tag,
  input  logic                in_valid,
  input  logic                out_ready,
  output alu_op_t             alu_ctrl,
  output logic                alu_advance,
  output logic                alu_regfile_en,
  input  logic                alu_op_done,
  output logic                done_valid,
  output logic [TAG_BITS-1:0] done_tag,
  output logic                busy
);

  localparam int unsigned StepsSingle = REG_BITS / NSHIFT;
  localparam int unsigned StepsPair   = 2 * StepsSingle;
  localparam int unsigned CntW        = $clog2(StepsPair + 1);
  localparam logic [CntW-1:0] LastSingle = CntW'(StepsSingle - 1);
  localparam logic [CntW-1:0] LastPair   = CntW'(StepsPair - 1);

  seq_state_t          state_q, state_d;
  alu_op_t             cur_op_q, cur_op_d;
  logic [TAG_BITS-1:0] cur_tag_q, cur_tag_d;
  logic                done_valid_q, done_valid_d;
  logic [TAG_BITS-1:0] done_tag_q, done_tag_d;
  logic [CntW-1:0]     step_cnt_q, step_cnt_d;

  logic                step;
  logic                last_step;
  logic                accept;
  logic                skid_full;
  alu_op_t             skid_op;
  logic [TAG_BITS-1:0] skid_tag;

  assign accept = req_valid && req_ready;

`ifdef ALU_SEQ_SKID_EN
  logic skid_push;
  logic skid_pop;

  // While running, a request lands in the skid unless it can be loaded on this last step.
  assign skid_push = accept && (state_q == SEQ_RUN) && !last_step;
  assign skid_pop  = last_step && skid_full;
  assign req_ready = !skid_full;

  alu_seq_skid #(
    .TagBits(TAG_BITS)
  ) u_skid (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (skid_push),
    .pop_i  (skid_pop),
    .op_i   (req_op),
    .tag_i  (req_tag),
    .full_o (skid_full),
    .op_o   (skid_op),
    .tag_o  (skid_tag)
  );
`else
  assign skid_full = 1'b0;
  assign skid_op   = '0;
  assign skid_tag  = '0;
  assign req_ready = (state_q == SEQ_IDLE);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SEQ_IDLE;
      cur_op_q     <= '0;
      cur_tag_q    <= '0;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      step_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_op_q     <= cur_op_d;
      cur_tag_q    <= cur_tag_d;
      done_valid_q <= done_valid_d;
      done_tag_q   <= done_tag_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cur_op_d  = cur_op_q;
    cur_tag_d = cur_tag_q;
    case (state_q)
      SEQ_IDLE: begin
        if (accept) begin
          state_d   = SEQ_RUN;
          cur_op_d  = req_op;
          cur_tag_d = req_tag;
        end
      end
      SEQ_RUN: begin
        if (last_step) begin
          if (skid_full) begin
            cur_op_d  = skid_op;
            cur_tag_d = skid_tag;
          end else if (accept) begin
            cur_op_d  = req_op;
            cur_tag_d = req_tag;
          end else begin
            state_d = SEQ_IDLE;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Step enable, completion and outputs.
  always_comb begin
    step = (state_q == SEQ_RUN) &&
           (!cur_op_q.needs_in || in_valid) &&
           (!cur_op_q.needs_out || out_ready);
    last_step    = step && alu_op_done;
    done_valid_d = last_step;
    done_tag_d   = last_step ? cur_tag_q : done_tag_q;

    // Tracks steps of the running op so the ALU's op_done can be cross-checked.
    step_cnt_d = step_cnt_q;
    if (last_step || (state_q == SEQ_IDLE)) begin
      step_cnt_d = '0;
    end else if (step) begin
      step_cnt_d = step_cnt_q + 1'b1;
    end

    alu_ctrl       = cur_op_q;
    alu_advance    = step;
    alu_regfile_en = step;
    done_valid     = done_valid_q;
    done_tag       = done_tag_q;
    busy           = (state_q == SEQ_RUN) || skid_full;
  end

  assert property (@(posedge clk) disable iff (reset)
    last_step |-> (step_cnt_q == (cur_op_q.pair_op ? LastPair : LastSingle)));

  assert property (@(posedge clk)
    ($bits(cur_op_q.reg1) == LOG2_NR) && ($bits(cur_op_q.operation) == OP_BITS));

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural step-counting ALU model.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  alu_op_t    req_op = '0;
  logic [2:0] req_tag = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  alu_op_t    alu_ctrl;
  logic       alu_advance;
  logic       alu_regfile_en;
  logic       alu_op_done;
  logic       done_valid;
  logic [2:0] done_tag;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] tag;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  alu_sequencer #(
    .LOG2_NR (4),
    .REG_BITS(8),
    .NSHIFT  (2),
    .TAG_BITS(3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_tag       (req_tag),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .alu_ctrl      (alu_ctrl),
    .alu_advance   (alu_advance),
    .alu_regfile_en(alu_regfile_en),
    .alu_op_done   (alu_op_done),
    .done_valid    (done_valid),
    .done_tag      (done_tag),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: 4 steps per byte op, 8 per pair op.
  logic [3:0] alu_cnt;
  assign alu_op_done = (alu_cnt == (alu_ctrl.pair_op ? 4'd7 : 4'd3));
  always @(posedge clk) begin
    if (reset) alu_cnt <= 4'd0;
    else if (alu_advance) alu_cnt <= alu_op_done ? 4'd0 : alu_cnt + 4'd1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done @cycle %0d: got tag %0d, want no completion", cyc,
                 done_tag);
      end else begin
        e = sb_q.pop_front();
        chk("done_tag", 64'(done_tag), 64'(e.tag));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic alu_op_t mk(input logic [AluOpBits-1:0] opc, input logic pair,
                                 input logic nin, input logic nout);
    alu_op_t o;
    o           = '0;
    o.operation = opc;
    o.reg1      = 4'd3;
    o.reg2      = 4'd9;
    o.pair_op   = pair;
    o.update_reg1 = 1'b1;
    o.needs_in  = nin;
    o.needs_out = nout;
    return o;
  endfunction

  task automatic expect_done(input logic [2:0] tag, input int at);
    exp_t e;
    e.tag = tag;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic run_op(input string nm, input alu_op_t op, input logic [2:0] tag,
                        input logic [15:0] in_pat, input logic [15:0] out_pat,
                        input logic [15:0] adv_exp, input int done_rel);
    int base;
    @(negedge clk);
    base      = cyc;
    req_op    = op;
    req_tag   = tag;
    req_valid = 1'b1;
    in_valid  = in_pat[0];
    out_ready = out_pat[0];
    #1;
    chk({nm, "_ready"}, 64'(req_ready), 64'd1);
    expect_done(tag, base + done_rel);
    for (int r = 1; r <= done_rel + 1; r++) begin
      @(negedge clk);
      req_valid = 1'b0;
      in_valid  = in_pat[r];
      out_ready = out_pat[r];
      #1;
      chk({nm, "_adv"}, 64'(alu_advance), 64'(adv_exp[r]));
      chk({nm, "_rfen"}, 64'(alu_regfile_en), 64'(adv_exp[r]));
      chk({nm, "_ctrl"}, 64'(alu_ctrl), 64'(op));
      chk({nm, "_busy"}, 64'(busy), 64'(r < done_rel));
    end
  endtask

  task automatic back_to_back();
    alu_op_t    op_a, op_b;
    int         base;
    logic       rdy;
    logic [15:0] adv_exp;
`ifdef ALU_SEQ_SKID_EN
    adv_exp = 16'h01FE;
`else
    adv_exp = 16'h03DE;
`endif
    op_a = mk(6'd1, 1'b0, 1'b0, 1'b0);
    op_b = mk(6'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    base      = cyc;
    req_op    = op_a;
    req_tag   = 3'd2;
    req_valid = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("b2b_ready0", 64'(req_ready), 64'd1);
    expect_done(3'd2, base + 5);
    @(negedge clk);
    req_op  = op_b;
    req_tag = 3'd7;
    #1;
`ifdef ALU_SEQ_SKID_EN
    chk("b2b_ready1", 64'(req_ready), 64'd1);
    expect_done(3'd7, base + 9);
`else
    chk("b2b_ready1", 64'(req_ready), 64'd0);
    expect_done(3'd7, base + 10);
`endif
    chk("b2b_adv", 64'(alu_advance), 64'(adv_exp[1]));
    rdy = req_ready;
    for (int r = 2; r <= 11; r++) begin
      @(negedge clk);
      if (req_valid && rdy) req_valid = 1'b0;
      #1;
      chk("b2b_adv", 64'(alu_advance), 64'(adv_exp[r]));
      if (r == 4) chk("b2b_ctrl_a", 64'(alu_ctrl), 64'(op_a));
      if (r == 6) chk("b2b_ctrl_b", 64'(alu_ctrl), 64'(op_b));
      if (req_valid) rdy = req_ready;
    end
    chk("b2b_req_taken", 64'(req_valid), 64'd0);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    req_op    = mk(6'd2, 1'b1, 1'b0, 1'b0);
    req_tag   = 3'd4;
    req_valid = 1'b1;
    #1;
    chk("rst_ready0", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_step2_adv", 64'(alu_advance), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_adv", 64'(alu_advance), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_done", 64'(done_valid), 64'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("rst_idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_adv", 64'(alu_advance), 64'd0);
    chk("reset_rfen", 64'(alu_regfile_en), 64'd0);
    chk("reset_done", 64'(done_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ctrl", 64'(alu_ctrl), 64'd0);
    chk("reset_tag", 64'(done_tag), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // Byte ADD, serial I/O ignored: steps 1..4, done 5.
    run_op("add", mk(6'd1, 1'b0, 1'b0, 1'b0), 3'd5, 16'h0000, 16'h0000, 16'h001E, 5);
    // Pair MOV: steps 1..8, done 9.
    run_op("mov", mk(6'd2, 1'b1, 1'b0, 1'b0), 3'd3, 16'h0000, 16'h0000, 16'h01FE, 9);
    // in_valid low in cycles 2-3: steps 1,4,5,6, done 7.
    run_op("install", mk(6'd4, 1'b0, 1'b1, 1'b0), 3'd6, 16'hFFF3, 16'h0000, 16'h0072, 7);
    // out_ready toggling from cycle 1: steps 1,3,5,7, done 8.
    run_op("outbp", mk(6'd5, 1'b0, 1'b0, 1'b1), 3'd1, 16'h0000, 16'hAAAA, 16'h00AA, 8);

    back_to_back();
    reset_mid_op();

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
